ksa: RTL and testbench

Key-scheduling stage of the ARC4 decryption datapath. Runs once the S memory holds the identity permutation (S[i] = i). It performs the 256 ARC4 key-scheduling swaps on the shared S memory using a 24-bit key, then hands S over to the pseudo-random generation stage. It uses the same en/rdy handshake and S-memory port conventions as the other stages that share that memory.

---
 rtl/ksa.sv | 158 +++++++++++++++
 tb/tb_ksa.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa.sv
// ---------------------------------------------------------------------------
// ksa -- ARC4 key-scheduling stage.
//
// Starting from an S memory that holds the identity permutation, performs the
// 256 key-scheduling swaps using a 24-bit key. Each swap takes six cycles:
// read S[i], latch it and advance j, read S[j], latch it, write S[i], then
// write S[j]. The shared S memory is a synchronous RAM. Read data returns one
// cycle after the address is presented. A write takes effect at the rising
// edge.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous, active-high reset
//   en        in   1   start request, sampled only while rdy = 1
//   rdy       out  1   1 = idle, able to accept en
//   key       in  24   key[23:16] = byte 0, key[15:8] = byte 1, key[7:0] = byte 2
//   s_addr    out  8   S memory address
//   s_rddata  in   8   S memory read data (one cycle after s_addr)
//   s_wrdata  out  8   S memory write data
//   s_wren    out  1   S memory write enable
// ---------------------------------------------------------------------------
module ksa (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_I,
    ST_LAT_I,
    ST_RD_J,
    ST_LAT_J,
    ST_WR_I,
    ST_WR_J
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [23:0] kreg_q, kreg_d;

  // Key byte used at index idx: byte (idx mod 3), with byte 0 in the top bits.
  // Index 255 gives 255 mod 3 = 0, so the last iteration uses byte 0.
  function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [7:0] idx);
    logic [7:0] sel;
    logic [7:0] kb;
    sel = idx % 8'd3;
    case (sel)
      8'd0:    kb = k[23:16];
      8'd1:    kb = k[15:8];
      default: kb = k[7:0];
    endcase
    return kb;
  endfunction

  // Next-state logic and Moore outputs
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    kreg_d   = kreg_q;
    rdy      = 1'b0;
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          // Latch the key now so that later changes on the key port do not
          // affect the run in progress.
          kreg_d  = key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          state_d = ST_RD_I;
        end
      end

      ST_RD_I: begin
        s_addr  = i_q;
        state_d = ST_LAT_I;
      end

      ST_LAT_I: begin
        // j wraps modulo 256. The 8-bit sum discards the carries.
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + key_byte(kreg_q, i_q);
        state_d = ST_RD_J;
      end

      ST_RD_J: begin
        s_addr  = j_q;
        state_d = ST_LAT_J;
      end

      ST_LAT_J: begin
        sj_d    = s_rddata;
        state_d = ST_WR_I;
      end

      ST_WR_I: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = ST_WR_J;
      end

      ST_WR_J: begin
        // When i == j this second write lands on the same word and restores
        // the original value. That is the correct ARC4 result.
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        if (i_q == 8'd255) begin
          state_d = ST_IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = ST_RD_I;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      kreg_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kreg_q  <= kreg_d;
    end
  end

endmodule

// File: tb/tb_ksa.sv
// ---------------------------------------------------------------------------
// tb_ksa -- self-checking bench for the ARC4 key-scheduling stage.
// The bench provides a synchronous 256 x 8 S memory, a write-trace recorder
// and a software KSA reference.
// ---------------------------------------------------------------------------
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  always #5 clk = ~clk;

  ksa dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  // Synchronous S memory and write recorder
  logic [7:0] mem [256];
  logic       init_req = 1'b0;
  int         wr_a [$];
  int         wr_d [$];

  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= k[7:0];
    end else if (s_wren) begin
      mem[s_addr] <= s_wrdata;
    end
    s_rddata <= mem[s_addr];
    if (s_wren) begin
      wr_a.push_back(int'(s_addr));
      wr_d.push_back(int'(s_wrdata));
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_s [256];
  logic [7:0] ref0    [256];

  // Software ARC4 key schedule
  task automatic compute_model(input logic [23:0] k);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int n = 0; n < 256; n++) model_s[n] = n[7:0];
    for (int n = 0; n < 256; n++) begin
      case (n % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j = j + model_s[n] + kb;
      t = model_s[n];
      model_s[n] = model_s[j];
      model_s[j] = t;
    end
  endtask

  task automatic init_s();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Starts one run and counts the cycles with rdy low.
  // en is pulsed during busy cycle pulse_at, and key is changed at rekey_at.
  task automatic do_run(input logic [23:0] k, input int pulse_at, input int rekey_at,
                        input logic [23:0] rekey_val, output int busy, output int wbase);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rdy && guard < 4000) begin
      guard++;
      @(negedge clk);
    end
    key   = k;
    wbase = wr_a.size();
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en   = 1'b0;
    busy = 0;
    while (!rdy && busy < 4000) begin
      busy++;
      en = (busy == pulse_at);
      if (busy == rekey_at) key = rekey_val;
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    key = 24'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    n_tests++;
    if (s_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", s_addr); end
    n_tests++;
    if (s_wrdata !== 8'd0) begin n_fail++; $display("FAIL reset_wrdata got=%0d exp=0", s_wrdata); end
    n_tests++;
    if (s_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%b exp=0", s_wren); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset rdy got=%b exp=1", rdy); end
  endtask

  task automatic test_key_zero();
    int busy, wbase, ga, gd, bad;
    int exp_a [8] = '{0, 0, 1, 1, 2, 3, 3, 5};
    int exp_d [8] = '{0, 0, 1, 1, 3, 2, 5, 2};
    init_s();
    do_run(24'h000000, 0, 0, 24'h0, busy, wbase);
    n_tests++;
    if (busy !== 1536) begin n_fail++; $display("FAIL k0_busy_cycles got=%0d exp=1536", busy); end
    n_tests++;
    if (wr_a.size() - wbase !== 512) begin
      n_fail++; $display("FAIL k0_write_count got=%0d exp=512", wr_a.size() - wbase);
    end
    for (int k = 0; k < 8; k++) begin
      ga = (wbase + k < wr_a.size()) ? wr_a[wbase + k] : -1;
      gd = (wbase + k < wr_d.size()) ? wr_d[wbase + k] : -1;
      n_tests++;
      if (ga !== exp_a[k] || gd !== exp_d[k]) begin
        n_fail++;
        $display("FAIL k0_trace[%0d] got=(%0d,%0d) exp=(%0d,%0d)", k, ga, gd, exp_a[k], exp_d[k]);
      end
    end
    compute_model(24'h000000);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_s[k]) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL k0_final_s mismatched_bytes=%0d exp=0", bad); end
    for (int k = 0; k < 256; k++) ref0[k] = model_s[k];
  endtask

  task automatic test_byte_order();
    int busy, wbase, ga, gd;
    init_s();
    do_run(24'h000001, 0, 0, 24'h0, busy, wbase);
    ga = (wbase + 4 < wr_a.size()) ? wr_a[wbase + 4] : -1;
    gd = (wbase + 4 < wr_d.size()) ? wr_d[wbase + 4] : -1;
    n_tests++;
    if (ga !== 2 || gd !== 4) begin n_fail++; $display("FAIL byteorder_wr_i got=(%0d,%0d) exp=(2,4)", ga, gd); end
    ga = (wbase + 5 < wr_a.size()) ? wr_a[wbase + 5] : -1;
    gd = (wbase + 5 < wr_d.size()) ? wr_d[wbase + 5] : -1;
    n_tests++;
    if (ga !== 4 || gd !== 2) begin n_fail++; $display("FAIL byteorder_wr_j got=(%0d,%0d) exp=(4,2)", ga, gd); end
  endtask

  task automatic test_j_wrap();
    int busy, wbase, ga, gd, bad;
    init_s();
    do_run(24'hFF0000, 0, 0, 24'h0, busy, wbase);
    ga = (wbase < wr_a.size()) ? wr_a[wbase] : -1;
    gd = (wbase < wr_d.size()) ? wr_d[wbase] : -1;
    n_tests++;
    if (ga !== 0 || gd !== 255) begin n_fail++; $display("FAIL jwrap_wr_i got=(%0d,%0d) exp=(0,255)", ga, gd); end
    ga = (wbase + 1 < wr_a.size()) ? wr_a[wbase + 1] : -1;
    gd = (wbase + 1 < wr_d.size()) ? wr_d[wbase + 1] : -1;
    n_tests++;
    if (ga !== 255 || gd !== 0) begin n_fail++; $display("FAIL jwrap_wr_j got=(%0d,%0d) exp=(255,0)", ga, gd); end
    compute_model(24'hFF0000);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_s[k]) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL jwrap_final_s mismatched_bytes=%0d exp=0", bad); end
  endtask

  task automatic test_handshake();
    int busy, wbase, bad, lows;
    init_s();
    do_run(24'h123456, 500, 300, 24'hA5C3E1, busy, wbase);
    n_tests++;
    if (busy !== 1536) begin n_fail++; $display("FAIL hs_busy_cycles got=%0d exp=1536", busy); end
    compute_model(24'h123456);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_s[k]) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL hs_final_s mismatched_bytes=%0d exp=0", bad); end
    lows = 0;
    repeat (10) begin
      if (rdy !== 1'b1 || s_wren !== 1'b0) lows++;
      @(negedge clk);
    end
    n_tests++;
    if (lows !== 0) begin n_fail++; $display("FAIL hs_no_restart busy_cycles=%0d exp=0", lows); end
  endtask

  task automatic test_async_reset();
    int busy, wbase, bad;
    logic rdy_before;
    init_s();
    @(negedge clk);
    key = 24'h000000;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (699) @(negedge clk);
    rdy_before = rdy;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (rdy_before !== 1'b0) begin n_fail++; $display("FAIL arst_busy_before got=%b exp=0", rdy_before); end
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL arst_rdy got=%b exp=1", rdy); end
    n_tests++;
    if (s_wren !== 1'b0 || s_addr !== 8'd0) begin
      n_fail++; $display("FAIL arst_outputs got wren=%b addr=%0d exp wren=0 addr=0", s_wren, s_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    init_s();
    do_run(24'h000000, 0, 0, 24'h0, busy, wbase);
    n_tests++;
    if (busy !== 1536) begin n_fail++; $display("FAIL arst_rerun_busy got=%0d exp=1536", busy); end
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref0[k]) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL arst_rerun_s mismatched_bytes=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    int busy1, high, busy2;
    init_s();
    @(negedge clk);
    key = 24'h010203;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busy1 = 0;
    while (!rdy && busy1 < 4000) begin busy1++; @(negedge clk); end
    high = 0;
    while (rdy && high < 20) begin high++; @(negedge clk); end
    busy2 = 0;
    while (!rdy && busy2 < 4000) begin busy2++; @(negedge clk); end
    en = 1'b0;
    n_tests++;
    if (busy1 !== 1536) begin n_fail++; $display("FAIL b2b_run1 got=%0d exp=1536", busy1); end
    n_tests++;
    if (high !== 1) begin n_fail++; $display("FAIL b2b_idle_gap got=%0d exp=1", high); end
    n_tests++;
    if (busy2 !== 1536) begin n_fail++; $display("FAIL b2b_run2 got=%0d exp=1536", busy2); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_key_zero();
    test_byte_order();
    test_j_wrap();
    test_handshake();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
